// File: rtl/nco_sweep_ctrl_if.sv
// NCO byte-wide load port: data byte, control byte and enable.
// The sweep sequencer is the master (initiator); the NCO is the slave.
interface nco_sweep_ctrl_if;
    logic [7:0] ncoDataIn;
    logic [7:0] ncoCtrlIn;
    logic       ncoEnable;

    modport master (
        output ncoDataIn,
        output ncoCtrlIn,
        output ncoEnable
    );

    modport slave (
        input ncoDataIn,
        input ncoCtrlIn,
        input ncoEnable
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer that programs the NCO FCW point by point.
// Optional macro NCO_SWEEP_TRIANGLE_EN: up/down (triangle) sweep.
module nco_sweep_ctrl #(
    parameter int DWELL_W = 16,
    parameter int FCW_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [FCW_W-1:0]   startFcw,
    input  logic [FCW_W-1:0]   stopFcw,
    input  logic [FCW_W-1:0]   stepFcw,
    input  logic [DWELL_W-1:0] dwellCycles,
    input  logic [1:0]         waveMode,
    input  logic               continuous,
    nco_sweep_ctrl_if.master   nco,
    output logic               busy,
    output logic               done,
    output logic [FCW_W-1:0]   curFcw
);

    if (FCW_W != 16) begin : gFcwCheck
        $error("nco_sweep_ctrl: FCW_W must be 16");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        DWELL,
        FIN
    } state_t;

    state_t             state;
    logic [7:0]         dataR;
    logic [7:0]         ctrlR;
    logic               enR;
    logic               busyR;
    logic               doneR;
    logic [FCW_W-1:0]   curR;
    logic [FCW_W-1:0]   startR;
    logic [FCW_W-1:0]   stopR;
    logic [FCW_W-1:0]   stepR;
    logic [DWELL_W-1:0] dwellR;
    logic [1:0]         modeR;
    logic               contR;
    logic [DWELL_W-1:0] dwellCnt;
    logic [DWELL_W-1:0] dwellLoad;

    logic [FCW_W:0]     sumUp;
    logic               upEnd;
    logic               haveNext;
    logic [FCW_W-1:0]   nextFcw;
`ifdef NCO_SWEEP_TRIANGLE_EN
    logic [FCW_W:0]     difDn;
    logic               dnEnd;
    logic               dirUp;
    logic               nextUp;
`endif

    assign nco.ncoDataIn = dataR;
    assign nco.ncoCtrlIn = ctrlR;
    assign nco.ncoEnable = enR;
    assign busy          = busyR;
    assign done          = doneR;
    assign curFcw        = curR;

    // A zero dwell still holds the point for one cycle.
    assign dwellLoad = (dwellR == '0) ? DWELL_W'(1) : dwellR;

    // Choose the next sweep point, or flag that the sweep has ended.
    always_comb begin
        sumUp    = {1'b0, curR} + {1'b0, stepR};
        upEnd    = sumUp[FCW_W] | (sumUp[FCW_W-1:0] > stopR)
                 | (stepR == '0);
        haveNext = 1'b1;
        nextFcw  = sumUp[FCW_W-1:0];
`ifdef NCO_SWEEP_TRIANGLE_EN
        difDn    = {1'b0, curR} - {1'b0, stepR};
        dnEnd    = difDn[FCW_W] | (difDn[FCW_W-1:0] < startR);
        nextUp   = 1'b1;
        if (dirUp) begin
            if (!upEnd) begin
                nextFcw = sumUp[FCW_W-1:0];
            end else if ((stepR != '0) && !dnEnd) begin
                nextFcw = difDn[FCW_W-1:0];
                nextUp  = 1'b0;
            end else if (contR && (stepR != '0)) begin
                nextFcw = startR;
            end else begin
                haveNext = 1'b0;
            end
        end else begin
            if (!dnEnd) begin
                nextFcw = difDn[FCW_W-1:0];
                nextUp  = 1'b0;
            end else if (contR) begin
                nextFcw = upEnd ? startR : sumUp[FCW_W-1:0];
            end else begin
                haveNext = 1'b0;
            end
        end
`else
        if (upEnd) begin
            if (contR && (stepR != '0)) begin
                nextFcw = startR;
            end else begin
                haveNext = 1'b0;
            end
        end
`endif
    end

    // Sweep FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dataR    <= '0;
            ctrlR    <= '0;
            enR      <= 1'b0;
            busyR    <= 1'b0;
            doneR    <= 1'b0;
            curR     <= '0;
            startR   <= '0;
            stopR    <= '0;
            stepR    <= '0;
            dwellR   <= '0;
            modeR    <= '0;
            contR    <= 1'b0;
            dwellCnt <= '0;
`ifdef NCO_SWEEP_TRIANGLE_EN
            dirUp    <= 1'b1;
`endif
        end else begin
            enR   <= 1'b1;
            doneR <= 1'b0;
            if (stop && (state != IDLE)) begin
                state <= IDLE;
                ctrlR <= '0;
                dataR <= '0;
                busyR <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        ctrlR <= '0;
                        dataR <= '0;
                        busyR <= 1'b0;
                        if (start && !stop) begin
                            startR <= startFcw;
                            stopR  <= stopFcw;
                            stepR  <= stepFcw;
                            dwellR <= dwellCycles;
                            modeR  <= waveMode;
                            contR  <= continuous;
                            curR   <= startFcw;
                            state  <= WR_LO;
                            ctrlR  <= {4'b0, 1'b0, 1'b1, waveMode};
                            dataR  <= startFcw[7:0];
                            busyR  <= 1'b1;
`ifdef NCO_SWEEP_TRIANGLE_EN
                            dirUp  <= 1'b1;
`endif
                        end
                    end
                    WR_LO: begin
                        state <= WR_HI;
                        ctrlR <= {4'b0, 1'b1, 1'b0, modeR};
                        dataR <= curR[15:8];
                    end
                    WR_HI: begin
                        state    <= DWELL;
                        ctrlR    <= {6'b0, modeR};
                        dataR    <= '0;
                        dwellCnt <= dwellLoad;
                    end
                    DWELL: begin
                        if (dwellCnt <= DWELL_W'(1)) begin
                            if (haveNext) begin
                                curR  <= nextFcw;
                                state <= WR_LO;
                                ctrlR <= {4'b0, 1'b0, 1'b1, modeR};
                                dataR <= nextFcw[7:0];
`ifdef NCO_SWEEP_TRIANGLE_EN
                                dirUp <= nextUp;
`endif
                            end else begin
                                state <= FIN;
                                doneR <= 1'b1;
                            end
                        end else begin
                            dwellCnt <= dwellCnt - DWELL_W'(1);
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        ctrlR <= '0;
                        dataR <= '0;
                        busyR <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
